heap_topk_stream: RTL and testbench
===================================

Name: heap_topk_stream

Overview:
- Streaming top-K selector for the feature-sorting path.
- Absorbs an unbounded stream of flagged key words and retains the DEPTH best entries in a sorted register array (parallel compare, one-cycle insert).
- On flush, drains the retained entries in sorted order over a valid/ready port.
- Successor to the fixed single-direction delay heap:
  - depth, key/data width and sort direction are parameters;
  - adds back-pressure on both ports, an occupancy count and a drop indication.

Parameters:
- DATA_WIDTH, 32, total word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are flags, bits [KEY_WIDTH-1:0] are the key, the middle bits are payload.
- KEY_WIDTH, 16, compare key width; must satisfy KEY_WIDTH <= DATA_WIDTH-2.
- DEPTH, 8, number of retained entries (K), 2..64.
- KEEP_LARGEST, 0, 0 = retain the DEPTH smallest keys and drain ascending; 1 = retain the DEPTH largest keys and drain descending.
- CNT_WIDTH, $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept an input word.
- in_data  in  DATA_WIDTH  input word.
- flush  in  1  single-cycle request to drain retained entries.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_WIDTH  drained word.
- out_last  out  1  marks the final drained word.
- count  out  CNT_WIDTH  number of retained entries.
- drop  out  1  one-cycle pulse: an accepted input was not stored.

Behaviour:
- Reset (async, rst=1) sets all outputs and state to zero:
  - in_ready=0, out_valid=0, out_last=0, out_data=0, count=0, drop=0, state=ACCEPT.
  - All slots are cleared to the sentinel: flag 2'b11 (worst) with key all-1s when KEEP_LARGEST=0; flag 2'b01 with key 0 when KEEP_LARGEST=1.
  - in_ready rises on the first clock edge after rst deasserts.
- Storage: slot[0..DEPTH-1], where slot[0] is the best entry.
  - Invariant: slots are sorted best to worst; slots at index >= count hold the sentinel.
- Compare: "better" means key strictly less (KEEP_LARGEST=0) or strictly greater (KEEP_LARGEST=1). Keys compare unsigned.
- ACCEPT state:
  - in_ready=1. A transfer occurs when in_valid & in_ready.
  - Words with flag != 2'b00 are accepted but not stored, and pulse drop.
  - Insertion uses position p = number of occupied slots that are better than or equal to the new key. Equal keys therefore insert after existing ones (stable).
  - If p < DEPTH: slots p..DEPTH-2 shift down by one, slot[p] takes in_data, and count increments (saturating at DEPTH). If the array was full, the old slot[DEPTH-1] is discarded and drop pulses.
  - If p == DEPTH (array full, new key not better than the worst): nothing is stored and drop pulses.
  - Results are visible in count and the slots on the cycle after the transfer.
- flush in ACCEPT:
  - If in_valid & in_ready in the same cycle, the word is inserted first and is included in the drain.
  - Next state is DRAIN. in_ready=0 from the next cycle.
- DRAIN state:
  - out_valid=1 while count>0; out_data=slot[0]; out_last=(count==1).
  - On out_valid & out_ready: slots shift up by one, the sentinel enters slot[DEPTH-1], and count decrements.
  - After the last handshake: out_valid=0 and state returns to ACCEPT, with in_ready=1 on the following cycle.
- Flush with count==0: DRAIN lasts one cycle with no output, then returns to ACCEPT.
- out_data and out_last hold stable while out_valid & !out_ready.
- flush during DRAIN is ignored.
- rst asserted mid-drain or mid-insert aborts immediately to the reset state; partial drains are lost.
- Throughput: one insert per cycle in ACCEPT, one output per cycle in DRAIN.
- Insert logic is a DEPTH-wide parallel compare plus a priority select; no multi-cycle path is permitted.

Optional Feature:
- Macro: HEAP_TOPK_DEDUP_EN.
- Defined: an input whose key equals the key of any occupied slot is not stored and pulses drop, so retained keys are unique.
- Undefined: duplicates are stored, inserted after existing equal keys.

Test Plan:
- DEPTH=4, KEEP_LARGEST=0; insert keys 9,3,7,1,5, then flush with out_ready=1 -> drop pulses on the 5th insert (9 evicted); output 1,3,5,7 with out_last on 7; count goes 4→0.
- KEEP_LARGEST=1, DEPTH=4; insert 2,8,8,4,6 -> drain outputs 8,8,6,4 (both 8s kept, stable order by payload); drop pulses once (2 evicted).
- Flag filter: insert a word with flag 2'b11 and key 0 -> not stored, drop=1, count unchanged.
- Back-pressure: drain with out_ready toggled 1,0,0,1 -> out_data is stable during the stall; no word is lost or duplicated; in_ready=0 throughout DRAIN.
- Same-cycle in_valid+flush with key 2 after 3 stored entries {4,6,8} -> drain outputs 2,4,6,8; flush with count=0 -> no out_valid, in_ready back high within 2 cycles.
- rst asserted after 2 of 4 outputs -> all outputs 0 immediately; the next flush yields no output; with HEAP_TOPK_DEDUP_EN, inserting key 5 twice gives count=1 and one drop pulse.

Source files
------------

// File: rtl/heap_topk_stream.sv
// Streaming top-K selector: keeps the DEPTH best keyed words in a sorted
// register array and drains them in order on flush.
// Optional: define HEAP_TOPK_DEDUP_EN to reject keys already retained.
module heap_topk_stream #(
   parameter int DATA_WIDTH   = 32,
   parameter int KEY_WIDTH    = 16,
   parameter int DEPTH        = 8,
   parameter bit KEEP_LARGEST = 1'b0,
   parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  drop
);

   typedef enum logic {
      ACCEPT = 1'b0,
      DRAIN  = 1'b1
   } state_t;

   // Empty slots hold a word that loses every comparison.
   function automatic logic [DATA_WIDTH-1:0] sentinel_f();
      logic [DATA_WIDTH-1:0] s;
      s = '0;
      if (KEEP_LARGEST) begin
         s[DATA_WIDTH-1 -: 2] = 2'b01;
      end else begin
         s[DATA_WIDTH-1 -: 2] = 2'b11;
         s[KEY_WIDTH-1:0]     = '1;
      end
      return s;
   endfunction

   localparam logic [DATA_WIDTH-1:0] SENTINEL = sentinel_f();
   localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = CNT_WIDTH'(1);

   function automatic logic better_f(
      input logic [KEY_WIDTH-1:0] a,
      input logic [KEY_WIDTH-1:0] b
   );
      return KEEP_LARGEST ? (a > b) : (a < b);
   endfunction

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] slot_q [DEPTH];
   logic [DATA_WIDTH-1:0] slot_d [DEPTH];
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  in_ready_q, in_ready_d;
   logic                  drop_q, drop_d;

   logic [DEPTH-1:0]      occ_v;
   logic [DEPTH-1:0]      keep_v;
   logic [DEPTH-1:0]      keep_sh;
   logic [KEY_WIDTH-1:0]  in_key;
   logic [1:0]            in_flag;
   logic                  xfer;
   logic                  full;
   logic                  is_dup;
   logic                  store;
   logic                  out_fire;

   assign in_key   = in_data[KEY_WIDTH-1:0];
   assign in_flag  = in_data[DATA_WIDTH-1 -: 2];
   assign xfer     = in_valid & in_ready_q & (state_q == ACCEPT);
   assign full     = (count_q == FULL_CNT);
   assign out_fire = out_valid & out_ready;

   // Parallel compare: a slot stays put if it is occupied and not worse.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         occ_v[i]  = (CNT_WIDTH'(i) < count_q);
         keep_v[i] = occ_v[i] &
                     !better_f(in_key, slot_q[i][KEY_WIDTH-1:0]);
      end
   end

   // keep_sh[i] says whether slot i-1 stays, so slot i is the insert point.
   assign keep_sh = {keep_v[DEPTH-2:0], 1'b1};

`ifdef HEAP_TOPK_DEDUP_EN
   logic [DEPTH-1:0] dup_v;

   // Flag any occupied slot whose key matches the incoming key.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         dup_v[i] = occ_v[i] & (in_key == slot_q[i][KEY_WIDTH-1:0]);
      end
   end

   assign is_dup = |dup_v;
`else
   assign is_dup = 1'b0;
`endif

   // A full array rejects keys no better than its worst entry.
   assign store = xfer & (in_flag == 2'b00) & !keep_v[DEPTH-1] & !is_dup;

   // Next-state, slot array update, count and drop.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      drop_d  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_d[i] = slot_q[i];
      end
      unique case (state_q)
         ACCEPT: begin
            if (store) begin
               slot_d[0] = keep_v[0] ? slot_q[0] : in_data;
               for (int i = 1; i < DEPTH; i++) begin
                  if (keep_v[i]) begin
                     slot_d[i] = slot_q[i];
                  end else if (keep_sh[i]) begin
                     slot_d[i] = in_data;
                  end else begin
                     slot_d[i] = slot_q[i-1];
                  end
               end
               if (!full) begin
                  count_d = count_q + ONE_CNT;
               end
               drop_d = full;
            end else begin
               drop_d = xfer;
            end
            if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (count_q == '0) begin
               state_d = ACCEPT;
            end else if (out_fire) begin
               for (int i = 0; i < DEPTH - 1; i++) begin
                  slot_d[i] = slot_q[i+1];
               end
               slot_d[DEPTH-1] = SENTINEL;
               count_d         = count_q - ONE_CNT;
               if (count_q == ONE_CNT) begin
                  state_d = ACCEPT;
               end
            end
         end
         default: begin
            state_d = ACCEPT;
         end
      endcase
      in_ready_d = (state_d == ACCEPT);
   end

   // State, slots and status registers with async reset to empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ACCEPT;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         drop_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= SENTINEL;
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         drop_q     <= drop_d;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign out_valid = (state_q == DRAIN) & (count_q != '0);
   assign out_data  = out_valid ? slot_q[0] : '0;
   assign out_last  = out_valid & (count_q == ONE_CNT);
   assign in_ready  = in_ready_q;
   assign count     = count_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_heap_topk_stream.sv
// Bench for heap_topk_stream: two DEPTH=4 instances (smallest / largest)
// checked against a sorted-queue reference model.
module tb_heap_topk_stream;

   localparam int DW = 32;
   localparam int KW = 16;
   localparam int D  = 4;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          in_valid  [2];
   logic          in_ready  [2];
   logic [DW-1:0] in_data   [2];
   logic          flush     [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic [DW-1:0] out_data  [2];
   logic          out_last  [2];
   logic [CW-1:0] count     [2];
   logic          drop      [2];

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] mq [2][$];

   heap_topk_stream #(
      .DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEPTH(D), .KEEP_LARGEST(1'b0)
   ) u_small (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .flush(flush[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_last(out_last[0]),
      .count(count[0]), .drop(drop[0])
   );

   heap_topk_stream #(
      .DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEPTH(D), .KEEP_LARGEST(1'b1)
   ) u_large (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .flush(flush[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_last(out_last[1]),
      .count(count[1]), .drop(drop[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] mk(input logic [1:0] f,
                                        input logic [13:0] p,
                                        input logic [15:0] kk);
      return {f, p, kk};
   endfunction

   function automatic bit better(input int k, input logic [KW-1:0] a,
                                 input logic [KW-1:0] b);
      return (k == 1) ? (a > b) : (a < b);
   endfunction

   // Reference: sorted list, insert after all not-worse entries, trim to D.
   function automatic bit model_ins(input int k, input logic [DW-1:0] w);
      int pos;
      if (w[DW-1 -: 2] != 2'b00) return 1'b1;
`ifdef HEAP_TOPK_DEDUP_EN
      for (int i = 0; i < mq[k].size(); i++) begin
         if (mq[k][i][KW-1:0] == w[KW-1:0]) return 1'b1;
      end
`endif
      pos = mq[k].size();
      for (int i = 0; i < mq[k].size(); i++) begin
         if (better(k, w[KW-1:0], mq[k][i][KW-1:0])) begin
            pos = i;
            break;
         end
      end
      mq[k].insert(pos, w);
      if (mq[k].size() > D) begin
         void'(mq[k].pop_back());
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic reset_checks();
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", in_ready[k], 0);
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_out_last", out_last[k], 0);
         chk("rst_out_data", out_data[k], 0);
         chk("rst_count", count[k], 0);
         chk("rst_drop", drop[k], 0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      reset_checks();
      mq[0].delete();
      mq[1].delete();
      @(negedge clk);
      rst = 1'b0;
      chk("in_ready_pre", in_ready[0], 0);
      tick();
      chk("in_ready_up0", in_ready[0], 1);
      chk("in_ready_up1", in_ready[1], 1);
   endtask

   task automatic ins(input int k, input logic [DW-1:0] w);
      bit d;
      chk("in_ready", in_ready[k], 1);
      in_valid[k] = 1'b1;
      in_data[k]  = w;
      tick();
      in_valid[k] = 1'b0;
      d = model_ins(k, w);
      chk("drop", drop[k], d);
      chk("count", count[k], mq[k].size());
   endtask

   // mode 0: always ready, 1: pattern 1,0,0,1, 2: random.
   task automatic drain_body(input int k, input int mode);
      int n;
      bit r;
      n = 0;
      while (mq[k].size() > 0 && n < 64) begin
         chk("in_ready_drain", in_ready[k], 0);
         chk("out_valid", out_valid[k], 1);
         chk("out_data", out_data[k], mq[k][0]);
         chk("out_last", out_last[k], mq[k].size() == 1);
         chk("count_drain", count[k], mq[k].size());
         case (mode)
            0:       r = 1'b1;
            1:       r = (n % 4 == 0) || (n % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready[k] = r;
         tick();
         out_ready[k] = 1'b0;
         if (r) void'(mq[k].pop_front());
         n++;
      end
      chk("drain_bound", mq[k].size(), 0);
      chk("out_valid_end", out_valid[k], 0);
      chk("out_last_end", out_last[k], 0);
      chk("count_end", count[k], 0);
      tick();
      chk("in_ready_end", in_ready[k], 1);
   endtask

   task automatic flush_drain(input int k, input int mode, input bit with_in,
                              input logic [DW-1:0] w);
      bit d;
      if (with_in) begin
         chk("in_ready_fl", in_ready[k], 1);
         in_valid[k] = 1'b1;
         in_data[k]  = w;
      end
      flush[k] = 1'b1;
      tick();
      flush[k]    = 1'b0;
      in_valid[k] = 1'b0;
      if (with_in) begin
         d = model_ins(k, w);
         chk("drop_flush", drop[k], d);
      end
      chk("in_ready_flush", in_ready[k], 0);
      drain_body(k, mode);
   endtask

   initial begin
      int k;
      int n;
      logic [1:0] f;
      logic [DW-1:0] w;

      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         flush[i]     = 1'b0;
         out_ready[i] = 1'b0;
      end
      #2;
      do_reset();

      ins(0, mk(2'b00, 14'd1, 16'd9));
      ins(0, mk(2'b00, 14'd2, 16'd3));
      ins(0, mk(2'b00, 14'd3, 16'd7));
      ins(0, mk(2'b00, 14'd4, 16'd1));
      ins(0, mk(2'b00, 14'd5, 16'd5));
      ins(0, mk(2'b11, 14'd6, 16'd0));
      flush_drain(0, 0, 1'b0, '0);

      ins(1, mk(2'b00, 14'd1, 16'd2));
      ins(1, mk(2'b00, 14'd2, 16'd8));
      ins(1, mk(2'b00, 14'd3, 16'd8));
      ins(1, mk(2'b00, 14'd4, 16'd4));
      ins(1, mk(2'b00, 14'd5, 16'd6));
      flush_drain(1, 1, 1'b0, '0);

      ins(0, mk(2'b00, 14'd7, 16'd4));
      ins(0, mk(2'b00, 14'd8, 16'd6));
      ins(0, mk(2'b00, 14'd9, 16'd8));
      flush_drain(0, 0, 1'b1, mk(2'b00, 14'd10, 16'd2));
      flush_drain(0, 0, 1'b0, '0);

      for (int i = 0; i < 4; i++) begin
         ins(0, mk(2'b00, 14'(20 + i), 16'(10 - 2 * i)));
      end
      flush[0] = 1'b1;
      tick();
      flush[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("pre_rst_data", out_data[0], mq[0][0]);
         out_ready[0] = 1'b1;
         tick();
         void'(mq[0].pop_front());
      end
      out_ready[0] = 1'b0;
      do_reset();
      flush_drain(0, 0, 1'b0, '0);

      ins(0, mk(2'b00, 14'd1, 16'd5));
      ins(0, mk(2'b00, 14'd2, 16'd5));
      flush_drain(0, 2, 1'b0, '0);

      for (int r = 0; r < 40; r++) begin
         k = $urandom_range(0, 1);
         n = $urandom_range(0, 7);
         for (int i = 0; i < n; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            w = mk(f, 14'($urandom), 16'($urandom_range(0, 15)));
            ins(k, w);
         end
         if ($urandom_range(0, 3) == 0) begin
            w = mk(2'b00, 14'($urandom), 16'($urandom_range(0, 15)));
            flush_drain(k, 2, 1'b1, w);
         end else begin
            flush_drain(k, $urandom_range(0, 2), 1'b0, '0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
